// File: rtl/multiplier_pipelined_hs.sv
// multiplier_pipelined_hs: 3-stage limb-split WIDTH x WIDTH multiplier with
// signed/unsigned mode, valid/ready handshake (whole-pipe stall) and pass-through tag.
module multiplier_pipelined_hs #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 is_signed,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   r,
  output logic [TAG_W-1:0]     out_tag
);
  localparam int H = WIDTH / 2;
  logic               adv;
  logic               v1, v2;
  logic [H-1:0]       a_hi, a_lo, b_hi, b_lo;
  logic               a_neg, b_neg;
  logic [TAG_W-1:0]   t1, t2;
  logic [WIDTH-1:0]   pp_ll, pp_hl, pp_lh, pp_hh;
  logic [WIDTH:0]     corr;
  logic [2*WIDTH-1:0] sum;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  // Unsigned limb sum minus the two's-complement correction gives the signed product mod 2^(2W)
  assign sum = {pp_hh, {WIDTH{1'b0}}} + {{WIDTH{1'b0}}, pp_ll}
             + ({{WIDTH{1'b0}}, pp_hl} << H) + ({{WIDTH{1'b0}}, pp_lh} << H)
             - ({{(WIDTH-1){1'b0}}, corr} << WIDTH);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1    <= 1'b0;
      a_hi  <= '0;
      a_lo  <= '0;
      b_hi  <= '0;
      b_lo  <= '0;
      a_neg <= 1'b0;
      b_neg <= 1'b0;
      t1    <= '0;
    end else if (adv) begin
      v1 <= in_valid;
      if (in_valid) begin
        a_hi  <= a[WIDTH-1:H];
        a_lo  <= a[H-1:0];
        b_hi  <= b[WIDTH-1:H];
        b_lo  <= b[H-1:0];
        a_neg <= is_signed & a[WIDTH-1];
        b_neg <= is_signed & b[WIDTH-1];
        t1    <= in_tag;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2    <= 1'b0;
      pp_ll <= '0;
      pp_hl <= '0;
      pp_lh <= '0;
      pp_hh <= '0;
      corr  <= '0;
      t2    <= '0;
    end else if (adv) begin
      v2 <= v1;
      if (v1) begin
        pp_ll <= {{H{1'b0}}, a_lo} * {{H{1'b0}}, b_lo};
        pp_hl <= {{H{1'b0}}, a_hi} * {{H{1'b0}}, b_lo};
        pp_lh <= {{H{1'b0}}, a_lo} * {{H{1'b0}}, b_hi};
        pp_hh <= {{H{1'b0}}, a_hi} * {{H{1'b0}}, b_hi};
        corr  <= {1'b0, (a_neg ? {b_hi, b_lo} : {WIDTH{1'b0}})}
               + {1'b0, (b_neg ? {a_hi, a_lo} : {WIDTH{1'b0}})};
        t2    <= t1;
      end
    end
  end
  // r/out_tag only load with a real result, so they hold across bubbles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      r         <= '0;
      out_tag   <= '0;
    end else if (adv) begin
      out_valid <= v2;
      if (v2) begin
        r       <= sum;
        out_tag <= t2;
      end
    end
  end
endmodule
